// File: rtl/bakery_ticket_arbiter_if.sv
// Request/grant bundle for bakery_ticket_arbiter.
// The requester side (master) drives req and observes the arbitration state.
// The arbiter (slave) samples req and publishes grant, ticket and queue state.
interface bakery_ticket_arbiter_if #(
   parameter int NPROC  = 4,
   parameter int TKMSB  = 3,
   parameter int SELMSB = 2
);
   logic [NPROC-1:0] req;
   logic [NPROC-1:0] grant;
   logic [SELMSB:0]  grant_idx;
   logic             busy;
   logic [TKMSB:0]   serving;
   logic [TKMSB:0]   next_ticket;
   logic [SELMSB:0]  queue_len;
   logic             revoke;

   modport master (
      output req,
      input  grant, grant_idx, busy, serving, next_ticket, queue_len, revoke
   );

   modport slave (
      input  req,
      output grant, grant_idx, busy, serving, next_ticket, queue_len, revoke
   );
endinterface

// File: rtl/bakery_ticket_arbiter.sv
// Bakery-style ticket arbiter: first-come, first-served mutual exclusion
// among NPROC requesters. Each requester takes a ticket from a wrapping
// counter on its rising request; only the holder of the now-serving ticket
// is granted. Same-edge takers get consecutive tickets ordered by index.
// A requester that drops its request before being granted keeps its ticket
// (ABANDON) so that serving can step over it in order.
// Optional feature macro BAKERY_HOLD_LIMIT_EN: limits a grant to MAXHOLD
// cycles, then revokes it and locks the requester out until req falls.
module bakery_ticket_arbiter #(
   parameter int NPROC   = 4,
   parameter int TKMSB   = 3,
   parameter int SELMSB  = 2,
   parameter int MAXHOLD = 200,
   parameter int HOLDMSB = 7
) (
   input  logic                  clock,
   input  logic                  reset_n,
   bakery_ticket_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_CS,
      ST_ABANDON,
      ST_LOCKOUT
   } state_t;

   localparam logic [TKMSB:0]  TK_ONE  = (TKMSB+1)'(1);
   localparam logic [SELMSB:0] SEL_ONE = (SELMSB+1)'(1);

   state_t           state_q [NPROC];
   state_t           state_d [NPROC];
   logic [TKMSB:0]   tk_q    [NPROC];
   logic [TKMSB:0]   tk_d    [NPROC];
   logic [TKMSB:0]   serving_q, serving_d;
   logic [TKMSB:0]   next_q, next_d;
   logic [NPROC-1:0] grant_q, grant_d;
   logic [SELMSB:0]  idx_q, idx_d;
   logic [SELMSB:0]  qlen_q, qlen_d;
   logic [TKMSB:0]   takers;
   logic             cs_any;

`ifdef BAKERY_HOLD_LIMIT_EN
   localparam logic [HOLDMSB:0] HOLD_ONE  = (HOLDMSB+1)'(1);
   localparam logic [HOLDMSB:0] HOLD_LAST = (HOLDMSB+1)'(MAXHOLD - 1);
   logic [HOLDMSB:0] hold_q, hold_d;
   logic             revoke_q, revoke_d;
`else
   // Hold-limit configuration has no effect in this build.
   logic [HOLDMSB:0] unused_hold_cfg;
   assign unused_hold_cfg = (HOLDMSB+1)'(MAXHOLD);
`endif

   // Per-requester transitions, ticket dispensing and next registered outputs
   always_comb begin
      state_d   = state_q;
      tk_d      = tk_q;
      serving_d = serving_q;
      next_d    = next_q;
      takers    = '0;
      cs_any    = 1'b0;
      grant_d   = '0;
      idx_d     = '0;
      qlen_d    = '0;
`ifdef BAKERY_HOLD_LIMIT_EN
      revoke_d  = 1'b0;
      hold_d    = hold_q;
`endif

      for (int i = 0; i < NPROC; i++) begin
         if (state_q[i] == ST_CS) cs_any = 1'b1;
      end

`ifdef BAKERY_HOLD_LIMIT_EN
      if (cs_any) hold_d = hold_q + HOLD_ONE;
`endif

      // Only one WAIT/ABANDON entry can hold the serving ticket, and a new
      // grant or an abandon skip needs an empty CS, so serving moves by at
      // most one per edge.
      for (int i = 0; i < NPROC; i++) begin
         case (state_q[i])
            ST_IDLE: begin
               if (bus.req[i]) begin
                  state_d[i] = ST_WAIT;
                  tk_d[i]    = next_q + takers;
                  takers     = takers + TK_ONE;
               end
            end
            ST_WAIT: begin
               if (!bus.req[i]) begin
                  state_d[i] = ST_ABANDON;
               end else if (!cs_any && (tk_q[i] == serving_q)) begin
                  state_d[i] = ST_CS;
`ifdef BAKERY_HOLD_LIMIT_EN
                  hold_d     = '0;
`endif
               end
            end
            ST_CS: begin
               if (!bus.req[i]) begin
                  state_d[i] = ST_IDLE;
                  serving_d  = serving_q + TK_ONE;
               end
`ifdef BAKERY_HOLD_LIMIT_EN
               else if (hold_q == HOLD_LAST) begin
                  state_d[i] = ST_LOCKOUT;
                  serving_d  = serving_q + TK_ONE;
                  revoke_d   = 1'b1;
               end
`endif
            end
            ST_ABANDON: begin
               if (!cs_any && (tk_q[i] == serving_q)) begin
                  state_d[i] = ST_IDLE;
                  serving_d  = serving_q + TK_ONE;
               end
            end
            ST_LOCKOUT: begin
               if (!bus.req[i]) state_d[i] = ST_IDLE;
            end
            default: state_d[i] = ST_IDLE;
         endcase
      end

      next_d = next_q + takers;

      for (int i = 0; i < NPROC; i++) begin
         if (state_d[i] == ST_CS) begin
            grant_d[i] = 1'b1;
            idx_d      = (SELMSB+1)'(i);
         end
         if ((state_d[i] == ST_WAIT) || (state_d[i] == ST_ABANDON)) begin
            qlen_d = qlen_d + SEL_ONE;
         end
      end
   end

   // Arbitration state and registered outputs; reset may land mid-grant
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NPROC; i++) begin
            state_q[i] <= ST_IDLE;
            tk_q[i]    <= '0;
         end
         serving_q <= '0;
         next_q    <= '0;
         grant_q   <= '0;
         idx_q     <= '0;
         qlen_q    <= '0;
      end else begin
         state_q   <= state_d;
         tk_q      <= tk_d;
         serving_q <= serving_d;
         next_q    <= next_d;
         grant_q   <= grant_d;
         idx_q     <= idx_d;
         qlen_q    <= qlen_d;
      end
   end

`ifdef BAKERY_HOLD_LIMIT_EN
   // Hold counter for the current owner and the one-cycle revoke pulse
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hold_q   <= '0;
         revoke_q <= 1'b0;
      end else begin
         hold_q   <= hold_d;
         revoke_q <= revoke_d;
      end
   end

   assign bus.revoke = revoke_q;
`else
   assign bus.revoke = 1'b0;
`endif

   assign bus.grant       = grant_q;
   assign bus.grant_idx   = idx_q;
   assign bus.busy        = |grant_q;
   assign bus.serving     = serving_q;
   assign bus.next_ticket = next_q;
   assign bus.queue_len   = qlen_q;

endmodule

// File: tb/tb_bakery_ticket_arbiter.sv
// Testbench for bakery_ticket_arbiter. Two instances: a 4-requester arbiter
// with 4-bit tickets, and a 3-requester arbiter with 2-bit tickets for the
// wrap-around case. Reference model: a FIFO of pending requesters in arrival
// order (ticket order), plus the current owner and lockout flags.
// Define BAKERY_HOLD_LIMIT_EN for both RTL and bench to cover the hold limit.
module tb_bakery_ticket_arbiter;

   localparam int MAXHOLD_TB = 5;
`ifdef BAKERY_HOLD_LIMIT_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset_n = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clock = ~clock;

   bakery_ticket_arbiter_if #(.NPROC(4), .TKMSB(3), .SELMSB(2)) bus_a ();
   bakery_ticket_arbiter_if #(.NPROC(3), .TKMSB(1), .SELMSB(1)) bus_b ();

   bakery_ticket_arbiter #(
      .NPROC(4), .TKMSB(3), .SELMSB(2), .MAXHOLD(MAXHOLD_TB), .HOLDMSB(7)
   ) dut_a (
      .clock(clock), .reset_n(reset_n), .bus(bus_a)
   );

   bakery_ticket_arbiter #(
      .NPROC(3), .TKMSB(1), .SELMSB(1), .MAXHOLD(MAXHOLD_TB), .HOLDMSB(7)
   ) dut_b (
      .clock(clock), .reset_n(reset_n), .bus(bus_b)
   );

   // ---------------- reference model ----------------
   int m_n, m_mod, m_holder, m_serving, m_next, m_hold;
   bit m_revoke;
   bit m_lock [8];
   int q_idx [$];
   bit q_ab  [$];

   function automatic void model_reset(input int n, input int md);
      m_n = n; m_mod = md; m_holder = -1; m_serving = 0; m_next = 0;
      m_hold = 0; m_revoke = 1'b0;
      q_idx.delete(); q_ab.delete();
      for (int i = 0; i < 8; i++) m_lock[i] = 1'b0;
   endfunction

   function automatic void model_step(input logic [7:0] r);
      bit busy_at [8];
      int was;
      was = m_holder;
      m_revoke = 1'b0;
      for (int i = 0; i < 8; i++) busy_at[i] = m_lock[i];
      foreach (q_idx[k]) busy_at[q_idx[k]] = 1'b1;
      if (was >= 0) busy_at[was] = 1'b1;
      for (int i = 0; i < 8; i++) if (m_lock[i] && !r[i]) m_lock[i] = 1'b0;
      if (was >= 0) begin
         if (!r[was]) begin
            m_holder = -1;
            m_serving = (m_serving + 1) % m_mod;
         end else if (HOLD_EN && m_hold == MAXHOLD_TB - 1) begin
            m_holder = -1;
            m_lock[was] = 1'b1;
            m_serving = (m_serving + 1) % m_mod;
            m_revoke = 1'b1;
         end else begin
            m_hold++;
         end
      end else if (q_idx.size() > 0) begin
         if (q_ab[0]) begin
            void'(q_idx.pop_front()); void'(q_ab.pop_front());
            m_serving = (m_serving + 1) % m_mod;
         end else if (r[q_idx[0]]) begin
            m_holder = q_idx.pop_front(); void'(q_ab.pop_front());
            m_hold = 0;
         end
      end
      for (int k = 0; k < q_ab.size(); k++) if (!r[q_idx[k]]) q_ab[k] = 1'b1;
      for (int i = 0; i < m_n; i++) begin
         if (!busy_at[i] && r[i]) begin
            q_idx.push_back(i); q_ab.push_back(1'b0);
            m_next = (m_next + 1) % m_mod;
         end
      end
   endfunction

   function automatic logic [19:0] exp_a();
      logic [3:0] g; logic [2:0] gi;
      g = '0; gi = '0;
      if (m_holder >= 0) begin g[m_holder] = 1'b1; gi = 3'(m_holder); end
      return {g, gi, |g, 4'(m_serving), 4'(m_next), 3'(q_idx.size()), m_revoke};
   endfunction

   function automatic logic [12:0] exp_b();
      logic [2:0] g; logic [1:0] gi;
      g = '0; gi = '0;
      if (m_holder >= 0) begin g[m_holder] = 1'b1; gi = 2'(m_holder); end
      return {g, gi, |g, 2'(m_serving), 2'(m_next), 2'(q_idx.size()), m_revoke};
   endfunction

   function automatic logic [19:0] obs_a();
      return {bus_a.grant, bus_a.grant_idx, bus_a.busy, bus_a.serving,
              bus_a.next_ticket, bus_a.queue_len, bus_a.revoke};
   endfunction

   function automatic logic [12:0] obs_b();
      return {bus_b.grant, bus_b.grant_idx, bus_b.busy, bus_b.serving,
              bus_b.next_ticket, bus_b.queue_len, bus_b.revoke};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick_a(input logic [3:0] r);
      bus_a.req = r;
      @(posedge clock);
      model_step({4'b0, r});
      #1;
   endtask

   task automatic tick_b(input logic [2:0] r);
      bus_b.req = r;
      @(posedge clock);
      model_step({5'b0, r});
      #1;
   endtask

   task automatic do_reset(input int n, input int md);
      bus_a.req = '0; bus_b.req = '0;
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset(n, md);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      bus_a.req = '0; bus_b.req = '0;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (obs_a() !== 20'h0) begin
         failures++; $display("FAIL reset_a got=%h exp=%h", obs_a(), 20'h0);
      end
      checks++;
      if (obs_b() !== 13'h0) begin
         failures++; $display("FAIL reset_b got=%h exp=%h", obs_b(), 13'h0);
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset(4, 16);
      tick_a(4'b0000);
      checks++;
      if (obs_a() !== exp_a()) begin
         failures++; $display("FAIL reset_idle got=%h exp=%h", obs_a(), exp_a());
      end
   endtask

   task automatic test_single();
      logic [3:0] seq [5];
      seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
      do_reset(4, 16);
      for (int c = 0; c < 5; c++) begin
         tick_a(seq[c]);
         checks++;
         if (obs_a() !== exp_a()) begin
            failures++; $display("FAIL single_model cyc=%0d got=%h exp=%h", c, obs_a(), exp_a());
         end
         if (c == 0) begin
            checks++;
            if ({bus_a.grant, bus_a.next_ticket, bus_a.queue_len} !== {4'b0000, 4'd1, 3'd1}) begin
               failures++;
               $display("FAIL single_ticket got=%b/%0d/%0d exp=0000/1/1",
                        bus_a.grant, bus_a.next_ticket, bus_a.queue_len);
            end
         end
         if (c == 1) begin
            checks++;
            if ({bus_a.grant, bus_a.grant_idx} !== {4'b0010, 3'd1}) begin
               failures++;
               $display("FAIL single_grant got=%b/%0d exp=0010/1", bus_a.grant, bus_a.grant_idx);
            end
         end
         if (c == 3) begin
            checks++;
            if ({bus_a.grant, bus_a.serving} !== {4'b0000, 4'd1}) begin
               failures++;
               $display("FAIL single_release got=%b/%0d exp=0000/1", bus_a.grant, bus_a.serving);
            end
         end
      end
   endtask

   task automatic test_tie();
      logic [3:0] r, prev;
      int order [$];
      do_reset(4, 16);
      r = 4'b1011; prev = '0;
      for (int c = 0; c < 30; c++) begin
         tick_a(r);
         checks++;
         if (obs_a() !== exp_a()) begin
            failures++; $display("FAIL tie_model cyc=%0d got=%h exp=%h", c, obs_a(), exp_a());
         end
         if (c == 0) begin
            checks++;
            if ({bus_a.next_ticket, bus_a.queue_len} !== {4'd3, 3'd3}) begin
               failures++;
               $display("FAIL tie_tickets got=%0d/%0d exp=3/3", bus_a.next_ticket, bus_a.queue_len);
            end
         end
         checks++;
         if (prev != 0 && bus_a.grant != 0 && bus_a.grant != prev) begin
            failures++; $display("FAIL tie_gap cyc=%0d got=%b after %b exp=idle", c, bus_a.grant, prev);
         end
         if (bus_a.grant != 0 && prev == 0) order.push_back(int'(bus_a.grant_idx));
         prev = bus_a.grant;
         r = r & ~bus_a.grant;
      end
      checks++;
      if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 3) begin
         failures++; $display("FAIL tie_order got=%p exp='{0,1,3}", order);
      end
   endtask

   task automatic test_abandon();
      logic [3:0] seq [7];
      seq = '{4'b0101, 4'b0101, 4'b0001, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
      do_reset(4, 16);
      for (int c = 0; c < 7; c++) begin
         tick_a(seq[c]);
         checks++;
         if (obs_a() !== exp_a()) begin
            failures++; $display("FAIL abandon_model cyc=%0d got=%h exp=%h", c, obs_a(), exp_a());
         end
         if (c == 3) begin
            checks++;
            if ({bus_a.grant, bus_a.serving, bus_a.queue_len} !== {4'b0000, 4'd1, 3'd1}) begin
               failures++;
               $display("FAIL abandon_release got=%b/%0d/%0d exp=0000/1/1",
                        bus_a.grant, bus_a.serving, bus_a.queue_len);
            end
         end
         if (c == 4) begin
            checks++;
            if ({bus_a.grant, bus_a.serving, bus_a.queue_len} !== {4'b0000, 4'd2, 3'd0}) begin
               failures++;
               $display("FAIL abandon_skip got=%b/%0d/%0d exp=0000/2/0",
                        bus_a.grant, bus_a.serving, bus_a.queue_len);
            end
         end
         if (c == 6) begin
            checks++;
            if (bus_a.grant !== 4'b0100) begin
               failures++; $display("FAIL abandon_retake got=%b exp=0100", bus_a.grant);
            end
         end
      end
      tick_a(4'b0000);
   endtask

   task automatic test_async_reset();
      logic [3:0] seq [5];
      seq = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010};
      do_reset(4, 16);
      for (int c = 0; c < 5; c++) begin
         tick_a(seq[c]);
         checks++;
         if (obs_a() !== exp_a()) begin
            failures++; $display("FAIL areset_model cyc=%0d got=%h exp=%h", c, obs_a(), exp_a());
         end
      end
      #3 reset_n = 1'b0;
      bus_a.req = '0;
      #1;
      checks++;
      if ({bus_a.grant, bus_a.busy, bus_a.serving, bus_a.next_ticket, bus_a.queue_len} !== 16'h0) begin
         failures++;
         $display("FAIL areset_clear got=%b/%b/%0d/%0d/%0d exp=0000/0/0/0/0", bus_a.grant,
                  bus_a.busy, bus_a.serving, bus_a.next_ticket, bus_a.queue_len);
      end
      #1 reset_n = 1'b1;
      model_reset(4, 16);
      for (int c = 0; c < 3; c++) begin
         tick_a(c < 2 ? 4'b0100 : 4'b0000);
         checks++;
         if (obs_a() !== exp_a()) begin
            failures++; $display("FAIL areset_rearb cyc=%0d got=%h exp=%h", c, obs_a(), exp_a());
         end
         if (c == 1) begin
            checks++;
            if ({bus_a.grant, bus_a.serving} !== {4'b0100, 4'd0}) begin
               failures++;
               $display("FAIL areset_ticket0 got=%b/%0d exp=0100/0", bus_a.grant, bus_a.serving);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      do_reset(4, 16);
      r = '0;
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < 4; i++) if ($urandom_range(3) == 0) r[i] = ~r[i];
         tick_a(r);
         checks++;
         if (obs_a() !== exp_a()) begin
            failures++; $display("FAIL random_model cyc=%0d got=%h exp=%h", c, obs_a(), exp_a());
         end
         checks++;
         if (!$onehot0(bus_a.grant)) begin
            failures++; $display("FAIL random_onehot cyc=%0d got=%b exp=onehot0", c, bus_a.grant);
         end
      end
   endtask

   task automatic test_wrap();
      logic [2:0] r, prev;
      int grants, wraps, cyc;
      logic [1:0] prev_srv;
      do_reset(3, 4);
      r = 3'b111; prev = '0; grants = 0; wraps = 0; cyc = 0; prev_srv = '0;
      while (grants < 10 && cyc < 100) begin
         tick_b(r);
         cyc++;
         checks++;
         if (obs_b() !== exp_b()) begin
            failures++; $display("FAIL wrap_model cyc=%0d got=%h exp=%h", cyc, obs_b(), exp_b());
         end
         checks++;
         if (!$onehot0(bus_b.grant)) begin
            failures++; $display("FAIL wrap_onehot cyc=%0d got=%b exp=onehot0", cyc, bus_b.grant);
         end
         if (bus_b.grant != 0 && prev == 0) begin
            checks++;
            if (bus_b.grant_idx !== 2'(grants % 3)) begin
               failures++;
               $display("FAIL wrap_order round=%0d got=%0d exp=%0d", grants, bus_b.grant_idx, grants % 3);
            end
            grants++;
         end
         if (prev_srv == 2'd3 && bus_b.serving == 2'd0) wraps++;
         prev_srv = bus_b.serving;
         prev = bus_b.grant;
         r = 3'b111 & ~bus_b.grant;
      end
      tick_b(3'b000);
      repeat (4) tick_b(3'b000);
      if (bus_b.serving == 2'd0 && prev_srv == 2'd3) wraps++;
      checks++;
      if (grants != 10 || wraps < 2) begin
         failures++; $display("FAIL wrap_rounds got=%0d/%0d exp=10/>=2", grants, wraps);
      end
      r = '0;
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < 3; i++) if ($urandom_range(3) == 0) r[i] = ~r[i];
         tick_b(r);
         checks++;
         if (obs_b() !== exp_b()) begin
            failures++; $display("FAIL wrap_random cyc=%0d got=%h exp=%h", c, obs_b(), exp_b());
         end
      end
   endtask

`ifdef BAKERY_HOLD_LIMIT_EN
   task automatic test_hold_limit();
      int g0, g2, rv;
      int first_after;
      do_reset(4, 16);
      g0 = 0; g2 = 0; rv = 0; first_after = -1;
      for (int c = 0; c < 16; c++) begin
         tick_a(c < 12 ? 4'b0101 : (c < 14 ? 4'b0100 : 4'b0101));
         checks++;
         if (obs_a() !== exp_a()) begin
            failures++; $display("FAIL hold_model cyc=%0d got=%h exp=%h", c, obs_a(), exp_a());
         end
         if (c < 12) begin
            if (bus_a.grant == 4'b0001) g0++;
            if (bus_a.grant == 4'b0100) begin
               g2++;
               if (first_after < 0) first_after = c;
            end
            if (bus_a.revoke) rv++;
         end
      end
      checks++;
      if (g0 != MAXHOLD_TB || g2 != MAXHOLD_TB || rv != 1 || first_after != 7) begin
         failures++;
         $display("FAIL hold_limit got=%0d/%0d/%0d/%0d exp=5/5/1/7", g0, g2, rv, first_after);
      end
   endtask
`endif

   initial begin
      bus_a.req = '0;
      bus_b.req = '0;
      test_reset();
      test_single();
      test_tie();
      test_abandon();
      test_async_reset();
      test_random();
      test_wrap();
`ifdef BAKERY_HOLD_LIMIT_EN
      test_hold_limit();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bakery_ticket_arbiter.md
Name: bakery_ticket_arbiter

Overview:
- Hardware ticket arbiter that shares one exclusive resource among NPROC requesters, serving them in first-come, first-served order.
- Each requester takes a ticket when it raises its request. The ticket counter is finite and wraps around.
- Only the holder of the "now serving" ticket is granted the resource. Same-cycle ties are broken by lower index.
- Sits in front of any shared datapath that the Param models place under mutual exclusion.

Parameters:
- NPROC, 4, number of requesters (2..8).
- TKMSB, 3, MSB of ticket and serving counters. Requires 2^(TKMSB+1) > NPROC.
- SELMSB, 2, MSB of index and count outputs. Must be able to represent NPROC.
- MAXHOLD, 200, grant hold limit in cycles (used only with the optional feature).
- HOLDMSB, 7, MSB of the hold counter.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  NPROC  per-requester request, level-sensitive.
- grant  output  NPROC  one-hot or zero grant, registered.
- grant_idx  output  SELMSB+1  index of the granted requester; 0 when idle.
- busy  output  1  OR of grant.
- serving  output  TKMSB+1  now-serving ticket.
- next_ticket  output  TKMSB+1  next ticket to dispense.
- queue_len  output  SELMSB+1  number of requesters in WAIT or ABANDON.
- revoke  output  1  one-cycle pulse on forced grant removal.

Behaviour:
- Reset (asynchronous, active-low): grant=0, grant_idx=0, busy=0, serving=0, next_ticket=0, queue_len=0, revoke=0. All per-requester state is IDLE and all tickets are 0. Reset may land mid-grant; it clears everything with no release handshake.
- Per-requester FSM states: IDLE, WAIT, CS, ABANDON, LOCKOUT (LOCKOUT is used only with the optional feature).
- IDLE -> WAIT when req[i]=1 at an edge.
  - The ticket is next_ticket + (number of lower-index requesters also leaving IDLE at that edge), mod 2^(TKMSB+1).
  - next_ticket advances by the number of new takers in that cycle.
  - Several requesters taking tickets in one cycle get consecutive tickets, ordered by index.
- WAIT -> CS at an edge when all three hold:
  - no requester is in CS;
  - tk[i]==serving;
  - req[i]=1.
  - grant[i] and grant_idx update at that same edge.
- Latency with the arbiter idle: req sampled at edge 0, ticket assigned at edge 0, grant high after edge 1.
- CS -> IDLE when req[i]=0 at an edge. At that edge grant clears and serving increments (wraps).
  - The next grant cannot occur before the following edge, so there is at least one cycle with grant=0 between owners.
- WAIT -> ABANDON when req[i]=0 at an edge before it is granted. The ticket is retained.
- ABANDON -> IDLE at the edge where serving==tk[i] and no requester is in CS. serving increments and no grant is issued.
  - req[i] is ignored while in ABANDON; a new ticket can only be taken from IDLE.
- Tickets are always consecutive and outstanding tickets are at most NPROC, so wrap-around is unambiguous. Equality comparison only; no magnitude compare.
- Simultaneous events at one edge: one release (serving++) plus any number of new ticket takers are all applied. The newly served requester is granted no earlier than the next edge.
- queue_len is registered and counts WAIT plus ABANDON requesters after each edge.
- Invariants: grant is one-hot or zero; at most one requester is in CS; serving never passes next_ticket.

Optional Feature:
- Macro: BAKERY_HOLD_LIMIT_EN.
- When defined:
  - A hold counter clears on each grant and increments each cycle in CS.
  - When the counter reaches MAXHOLD with req still high: grant clears, serving increments, revoke pulses for one cycle, and the requester moves CS -> LOCKOUT.
  - LOCKOUT -> IDLE on req=0.
- When undefined: no hold counter, the LOCKOUT state is unreachable, and revoke is tied to 0.

Test Plan:
- Single requester: req[1] rises at cycle 0 -> ticket 0; grant=4'b0010, grant_idx=1 after edge 1. req[1] falls -> grant=0, serving=1.
- Same-cycle tie: req=4'b1011 at cycle 0 -> tickets 0,1,2 for requesters 0,1,3; grants in order 0,1,3, each separated by at least one idle cycle; next_ticket=3.
- Abandon: requesters 0 and 2 queued; req[2] drops while requester 0 holds the grant. Requester 0 releases -> serving steps over requester 2's ticket with no grant, ending at 2; queue_len goes 1 -> 0.
- Wrap with TKMSB=1, NPROC=3: 10 grant/release rounds -> serving wraps 3 -> 0, order is preserved, grant is never two-hot.
- Async reset: assert reset_n=0 mid-grant between edges -> grant=0, serving=0, next_ticket=0 immediately; after release, req=1 re-arbitrates from ticket 0.
- With BAKERY_HOLD_LIMIT_EN, MAXHOLD=5: req[0] held high -> grant drops after 5 CS cycles, revoke=1 for one cycle, requester 2's waiting ticket is granted next, and req[0] is ignored until it falls.
